csr_regfile: RTL and testbench

- LoongArch control/status register file. It is the responder to the WB-stage CSR access interface (read, masked write, exception commit, ertn).
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL and TICLR.
- Runs the constant timer.
- Returns the exception entry (EENTRY) and return address (ERA).
- Generates the pending-interrupt flag that the front end turns into an INT exception.

---
 rtl/csr_regfile.sv | 189 ++++++++++++++++++
 tb/tb_csr_regfile.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// LoongArch LA32 control/status register file: CSR read/masked write, exception
// commit and ertn state updates, constant timer and pending-interrupt flag.
module csr_regfile #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        ws_ex,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic        ertn,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] era_entry,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0]  ECODE_ADE = 6'h08;
  localparam logic [5:0]  ECODE_ALE = 6'h09;
  localparam logic [8:0]  ESUB_ADEF = 9'h000;
  localparam logic [12:0] LIE_MASK  = 13'h1BFF;

  logic [1:0]         crmd_plv;
  logic               crmd_ie;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         estat_sw;
  logic [7:0]         estat_hw;
  logic               estat_ti;
  logic               estat_ipi;
  logic [5:0]         estat_ecode;
  logic [8:0]         estat_esub;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry;
  logic [31:0]        save0, save1, save2, save3;
  logic [31:0]        tid;
  logic [31:0]        tcfg;
  logic [TIMER_W-1:0] tval;

  logic [12:0]        estat_is;
  logic [31:0]        wdata;
  logic               wr;
  logic               tcfg_wr;
  logic               ticlr_clr;
  logic               timer_fire;

  assign estat_is = {estat_ipi, estat_ti, 1'b0, estat_hw, estat_sw};

  // Read mux; also supplies the old value for the masked-write merge below.
  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {28'h0, 1'b1, crmd_ie, crmd_plv};
      CSR_PRMD:   csr_rvalue = {29'h0, prmd_pie, prmd_pplv};
      CSR_ECFG:   csr_rvalue = {19'h0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub, estat_ecode, 3'h0, estat_is};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry, 6'h0};
      CSR_SAVE0:  csr_rvalue = save0;
      CSR_SAVE1:  csr_rvalue = save1;
      CSR_SAVE2:  csr_rvalue = save2;
      CSR_SAVE3:  csr_rvalue = save3;
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = 32'(tval);
      default:    csr_rvalue = 32'h0;
    endcase
  end

  // TICLR reads 0, so wdata[0] there is exactly (wvalue & wmask)[0].
  assign wdata      = (csr_wvalue & csr_wmask) | (csr_rvalue & ~csr_wmask);
  assign wr         = csr_we & ~ws_ex & ~ertn;
  assign tcfg_wr    = wr && (csr_num == CSR_TCFG);
  assign ticlr_clr  = wr && (csr_num == CSR_TICLR) && wdata[0];
  assign timer_fire = !tcfg_wr && tcfg[0] && (tval == TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv    <= 2'h0;
      crmd_ie     <= 1'b0;
      prmd_pplv   <= 2'h0;
      prmd_pie    <= 1'b0;
      ecfg_lie    <= 13'h0;
      estat_sw    <= 2'h0;
      estat_hw    <= 8'h0;
      estat_ti    <= 1'b0;
      estat_ipi   <= 1'b0;
      estat_ecode <= 6'h0;
      estat_esub  <= 9'h0;
      era         <= 32'h0;
      badv        <= 32'h0;
      eentry      <= 26'h0;
      save0       <= 32'h0;
      save1       <= 32'h0;
      save2       <= 32'h0;
      save3       <= 32'h0;
      tid         <= 32'h0;
      tcfg        <= 32'h0;
      tval        <= '0;
    end else begin
      if (ws_ex) begin
        prmd_pplv   <= crmd_plv;
        prmd_pie    <= crmd_ie;
        crmd_plv    <= 2'h0;
        crmd_ie     <= 1'b0;
        era         <= ws_pc;
        estat_ecode <= ws_ecode;
        estat_esub  <= ws_esubcode;
        if (ws_ecode == ECODE_ADE && ws_esubcode == ESUB_ADEF) begin
          badv <= ws_pc;
        end else if (ws_ecode == ECODE_ALE) begin
          badv <= ws_vaddr;
        end
      end else if (ertn) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr) begin
        case (csr_num)
          CSR_CRMD:   begin crmd_plv <= wdata[1:0]; crmd_ie <= wdata[2]; end
          CSR_PRMD:   begin prmd_pplv <= wdata[1:0]; prmd_pie <= wdata[2]; end
          CSR_ECFG:   ecfg_lie <= wdata[12:0] & LIE_MASK;
          CSR_ESTAT:  estat_sw <= wdata[1:0];
          CSR_ERA:    era      <= wdata;
          CSR_BADV:   badv     <= wdata;
          CSR_EENTRY: eentry   <= wdata[31:6];
          CSR_SAVE0:  save0    <= wdata;
          CSR_SAVE1:  save1    <= wdata;
          CSR_SAVE2:  save2    <= wdata;
          CSR_SAVE3:  save3    <= wdata;
          CSR_TID:    tid      <= wdata;
          CSR_TCFG:   tcfg     <= wdata;
          default:    ;
        endcase
      end

      estat_hw  <= hw_int_in;
      estat_ipi <= ipi_int_in;

      // Timer: a TCFG write reloads; a fire on the same edge as TICLR wins.
      if (tcfg_wr) begin
        tval <= {wdata[TIMER_W-1:2], 2'b00};
      end else if (tcfg[0] && tval != '0) begin
        if (tval == TIMER_W'(1)) begin
          tval <= tcfg[1] ? {tcfg[TIMER_W-1:2], 2'b00} : '0;
        end else begin
          tval <= tval - TIMER_W'(1);
        end
      end

      if (timer_fire) begin
        estat_ti <= 1'b1;
      end else if (ticlr_clr) begin
        estat_ti <= 1'b0;
      end
    end
  end

  assign has_int   = crmd_ie & (|(estat_is & ecfg_lie));
  assign ex_entry  = {eentry, 6'h0};
  assign era_entry = era;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: table of masked write/readback vectors
// plus hand-written exception, interrupt and timer sequences.
module tb_csr_regfile;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00c;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        ws_ex;
  logic [31:0] ws_pc;
  logic [31:0] ws_vaddr;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic        ertn;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_entry;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;

  always #5 clk = ~clk;

  csr_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .csr_num    (csr_num),
    .csr_rvalue (csr_rvalue),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .ws_ex      (ws_ex),
    .ws_pc      (ws_pc),
    .ws_vaddr   (ws_vaddr),
    .ws_ecode   (ws_ecode),
    .ws_esubcode(ws_esubcode),
    .ertn       (ertn),
    .has_int    (has_int),
    .ex_entry   (ex_entry),
    .era_entry  (era_entry),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  typedef struct {
    string       name;
    logic [13:0] num;
    logic [31:0] wval;
    logic [31:0] wmask;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[15];
  int   total  = 0;
  int   passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] act);
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb.pop_front();
      if ((act & e.mask) === (e.exp & e.mask)) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act & e.mask, e.exp & e.mask);
    end
  endtask

  task automatic rd(input string name, input logic [13:0] num, input logic [31:0] exp,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    csr_num = num;
    push(name, exp, mask);
    #1;
    pop_check(csr_rvalue);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    push(name, 32'(exp));
    pop_check(32'(act));
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] val,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    csr_num    = num;
    csr_wvalue = val;
    csr_wmask  = mask;
    csr_we     = 1'b1;
    tick();
    csr_we     = 1'b0;
    csr_wmask  = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [13:0] all_nums [14];

    reset = 1'b1; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    ws_ex = 1'b0; ws_pc = '0; ws_vaddr = '0; ws_ecode = '0; ws_esubcode = '0;
    ertn = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state of every implemented CSR
    all_nums = '{A_CRMD, A_PRMD, A_ECFG, A_ESTAT, A_ERA, A_BADV, A_EENTRY,
                 A_SAVE0, A_SAVE1, 14'h032, A_SAVE3, A_TID, A_TCFG, A_TVAL};
    foreach (all_nums[i]) begin
      rd($sformatf("reset_csr_%0h", all_nums[i]), all_nums[i],
         (all_nums[i] == A_CRMD) ? 32'h8 : 32'h0);
    end
    chk_bit("reset_has_int", has_int, 1'b0);
    push("reset_ex_entry", 32'h0);  pop_check(ex_entry);
    push("reset_era_entry", 32'h0); pop_check(era_entry);

    // Writable-bit masks and read-only behaviour
    vecs[0]  = '{"crmd_all",   A_CRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
    vecs[1]  = '{"crmd_ie_clr",A_CRMD,   32'h0000_0000, 32'h0000_0004, 32'h0000_000B};
    vecs[2]  = '{"prmd_all",   A_PRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
    vecs[3]  = '{"ecfg_all",   A_ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
    vecs[4]  = '{"estat_all",  A_ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[5]  = '{"era",        A_ERA,    32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[6]  = '{"badv",       A_BADV,   32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[7]  = '{"eentry",     A_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
    vecs[8]  = '{"save1",      A_SAVE1,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
    vecs[9]  = '{"save3_mask", A_SAVE3,  32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F};
    vecs[10] = '{"tid",        A_TID,    32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    vecs[11] = '{"tcfg_off",   A_TCFG,   32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[12] = '{"tval_ro",    A_TVAL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[13] = '{"unimpl",     14'h002,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{"ticlr_rd",   A_TICLR,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
    foreach (vecs[i]) begin
      push(vecs[i].name, vecs[i].exp);
      wr(vecs[i].num, vecs[i].wval, vecs[i].wmask);
      csr_num = vecs[i].num;
      #1;
      pop_check(csr_rvalue);
    end
    do_reset();

    // Masked write with same-cycle (old) and next-cycle (new) reads
    wr(A_SAVE0, 32'h1234_5678);
    csr_num = A_SAVE0; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'h0000_FF00; csr_we = 1'b1;
    push("save0_same_cycle", 32'h1234_5678);
    #1;
    pop_check(csr_rvalue);
    tick();
    csr_we = 1'b0;
    rd("save0_merged", A_SAVE0, 32'h1234_FF78);

    // Exception entry and ertn
    wr(A_EENTRY, 32'h1C00_8047);
    push("ex_entry", 32'h1C00_8040); pop_check(ex_entry);
    wr(A_CRMD, 32'h7);
    ws_ex = 1'b1; ws_pc = 32'h1C00_0100; ws_ecode = 6'h0B; ws_esubcode = 9'h0;
    tick();
    ws_ex = 1'b0;
    rd("ex_crmd", A_CRMD, 32'h8);
    rd("ex_prmd", A_PRMD, 32'h7);
    rd("ex_era", A_ERA, 32'h1C00_0100);
    rd("ex_ecode", A_ESTAT, 32'h000B_0000, 32'h003F_0000);
    rd("ex_badv_kept", A_BADV, 32'h0);
    push("ex_era_entry", 32'h1C00_0100); pop_check(era_entry);
    ertn = 1'b1;
    tick();
    ertn = 1'b0;
    rd("ertn_crmd", A_CRMD, 32'hF);

    // Exception (ADE/ADEF) beats a same-cycle ERA write; BADV takes pc
    csr_we = 1'b1; csr_num = A_ERA; csr_wvalue = 32'h5555_5555; csr_wmask = 32'hFFFF_FFFF;
    ws_ex = 1'b1; ws_pc = 32'h1C00_0200; ws_ecode = 6'h08; ws_esubcode = 9'h0;
    tick();
    csr_we = 1'b0; ws_ex = 1'b0;
    rd("ex_drops_we_era", A_ERA, 32'h1C00_0200);
    rd("adef_badv", A_BADV, 32'h1C00_0200);
    rd("adef_esub", A_ESTAT, 32'h0008_0000, 32'h7FFF_0000);

    // ALE captures vaddr
    ws_ex = 1'b1; ws_pc = 32'h1C00_0300; ws_vaddr = 32'hABCD_0003; ws_ecode = 6'h09;
    tick();
    ws_ex = 1'b0;
    rd("ale_badv", A_BADV, 32'hABCD_0003);

    // ws_ex wins over a same-cycle ertn (PRMD=0 before)
    wr(A_CRMD, 32'h7);
    ws_ex = 1'b1; ertn = 1'b1; ws_ecode = 6'h01;
    tick();
    ws_ex = 1'b0; ertn = 1'b0;
    rd("ex_over_ertn_prmd", A_PRMD, 32'h7);
    rd("ex_over_ertn_crmd", A_CRMD, 32'h8);

    // Hardware / IPI interrupt sampling and has_int gating
    hw_int_in = 8'hA5; ipi_int_in = 1'b1;
    tick();
    rd("is_sample", A_ESTAT, 32'h0000_1294, 32'h0000_1FFF);
    chk_bit("has_int_ie0", has_int, 1'b0);
    wr(A_ECFG, 32'h0000_1000);
    wr(A_CRMD, 32'h4);
    chk_bit("has_int_ipi", has_int, 1'b1);
    ipi_int_in = 1'b0;
    tick();
    chk_bit("has_int_ipi_drop", has_int, 1'b0);
    hw_int_in = 8'h00;
    tick();

    // One-shot timer
    wr(A_ECFG, 32'h0000_0800);
    wr(A_TCFG, 32'h0000_000D);
    rd("oneshot_load", A_TVAL, 32'd12);
    tick();
    rd("oneshot_dec", A_TVAL, 32'd11);
    repeat (10) tick();
    rd("oneshot_at1", A_TVAL, 32'd1);
    rd("oneshot_no_fire_yet", A_ESTAT, 32'h0, 32'h0000_0800);
    tick();
    rd("oneshot_zero", A_TVAL, 32'd0);
    rd("oneshot_fire", A_ESTAT, 32'h0000_0800, 32'h0000_0800);
    chk_bit("oneshot_has_int", has_int, 1'b1);
    repeat (3) tick();
    rd("oneshot_hold", A_TVAL, 32'd0);
    wr(A_TICLR, 32'h1);
    rd("ticlr_clear", A_ESTAT, 32'h0, 32'h0000_0800);
    chk_bit("ticlr_has_int", has_int, 1'b0);

    // Periodic timer, then TICLR on a fire edge
    wr(A_TCFG, 32'h0000_000B);
    rd("periodic_load", A_TVAL, 32'd8);
    repeat (7) tick();
    rd("periodic_at1", A_TVAL, 32'd1);
    tick();
    rd("periodic_reload", A_TVAL, 32'd8);
    rd("periodic_fire", A_ESTAT, 32'h0000_0800, 32'h0000_0800);
    wr(A_TICLR, 32'h1);
    rd("periodic_clr", A_ESTAT, 32'h0, 32'h0000_0800);
    rd("periodic_after_clr", A_TVAL, 32'd7);
    repeat (6) tick();
    rd("periodic_at1_again", A_TVAL, 32'd1);
    wr(A_TICLR, 32'h1);
    rd("fire_beats_ticlr", A_ESTAT, 32'h0000_0800, 32'h0000_0800);
    rd("fire_reload", A_TVAL, 32'd8);

    // Reset mid-countdown with a pending timer interrupt
    repeat (2) tick();
    do_reset();
    rd("rst_tval", A_TVAL, 32'h0);
    rd("rst_tcfg", A_TCFG, 32'h0);
    rd("rst_estat", A_ESTAT, 32'h0);
    rd("rst_crmd", A_CRMD, 32'h8);
    chk_bit("rst_has_int", has_int, 1'b0);
    repeat (3) tick();
    rd("rst_timer_stopped", A_TVAL, 32'h0);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
